// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory (slave).
interface mem_access_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: passes ALU results through, runs load/store bus
// transactions with pipeline stall, and produces the write-back bundle.
module mem_access #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned RAW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_reg,
    input  logic [RAW-1:0]  ex_waddr,
    input  logic [DW-1:0]   ex_wdata,
    input  logic [3:0]      ex_memop,
    input  logic [DW-1:0]   ex_sdata,
    output logic            stall_req,
    mem_access_if.master    dbus,
    output logic            mem_reg,
    output logic [RAW-1:0]  mem_waddr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_excp
);
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [3:0]     lat_op;
    logic [RAW-1:0] lat_waddr;
    logic [1:0]     lat_off;

    logic [AW-1:0]  addr_c;
    logic [1:0]     off_c;
    logic           is_load_c, is_store_c, is_byte_c, is_half_c, is_word_c;
    logic           access_c, misalign_c, issue_c, lat_load_c;
    logic [3:0]     be_c;
    logic [DW-1:0]  sdata_c;
    logic [7:0]     rbyte_c;
    logic [15:0]    rhalf_c;
    logic [DW-1:0]  load_data_c;

    // Decode of the op currently in EX/MEM
    assign addr_c     = AW'(ex_wdata);
    assign off_c      = ex_wdata[1:0];
    assign is_load_c  = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
    assign is_store_c = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
    assign is_byte_c  = (ex_memop == OP_LB) || (ex_memop == OP_LBU) || (ex_memop == OP_SB);
    assign is_half_c  = (ex_memop == OP_LH) || (ex_memop == OP_LHU) || (ex_memop == OP_SH);
    assign is_word_c  = (ex_memop == OP_LW) || (ex_memop == OP_SW);
    assign access_c   = ex_valid && (is_load_c || is_store_c);
    assign misalign_c = (is_half_c && off_c[0]) || (is_word_c && (off_c != 2'b00));
    assign issue_c    = (state == IDLE) && access_c && !misalign_c;
    assign lat_load_c = (lat_op >= OP_LB) && (lat_op <= OP_LW);

    always_comb begin
        be_c = 4'b1111;
        if (is_byte_c)      be_c = 4'(4'b0001 << off_c);
        else if (is_half_c) be_c = 4'(4'b0011 << off_c);
    end

    // Narrow stores are replicated across every lane; byte enables select the target
    always_comb begin
        sdata_c = ex_sdata;
        case (ex_memop)
            OP_SB:   sdata_c = DW'({4{ex_sdata[7:0]}});
            OP_SH:   sdata_c = DW'({2{ex_sdata[15:0]}});
            default: sdata_c = ex_sdata;
        endcase
    end

    assign rbyte_c = dbus.rdata[{lat_off, 3'b000} +: 8];
    assign rhalf_c = dbus.rdata[{lat_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data_c = dbus.rdata;
        case (lat_op)
            OP_LB:   load_data_c = {{(DW-8){rbyte_c[7]}}, rbyte_c};
            OP_LBU:  load_data_c = {{(DW-8){1'b0}}, rbyte_c};
            OP_LH:   load_data_c = {{(DW-16){rhalf_c[15]}}, rhalf_c};
            OP_LHU:  load_data_c = {{(DW-16){1'b0}}, rhalf_c};
            default: load_data_c = dbus.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        mem_reg   = 1'b0;
        mem_waddr = ex_waddr;
        mem_wdata = ex_wdata;
        mem_excp  = 1'b0;
        case (state)
            IDLE: begin
                if (access_c) begin
                    if (misalign_c) begin
                        mem_excp = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                        state_nxt = WAIT;
                    end
                end else begin
                    mem_reg = ex_valid && ex_reg;
                end
            end
            WAIT: begin
                if (dbus.ack) begin
                    state_nxt = IDLE;
                    if (lat_load_c) begin
                        mem_reg   = 1'b1;
                        mem_waddr = lat_waddr;
                        mem_wdata = load_data_c;
                    end
                end else begin
                    stall_req = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drive and latched op; held stable for the whole WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= '0;
            dbus.be    <= 4'b0000;
            dbus.wdata <= '0;
            lat_op     <= OP_NONE;
            lat_waddr  <= '0;
            lat_off    <= 2'b00;
        end else if (issue_c) begin
            dbus.req   <= 1'b1;
            dbus.we    <= is_store_c;
            dbus.addr  <= {addr_c[AW-1:2], 2'b00};
            dbus.be    <= be_c;
            dbus.wdata <= sdata_c;
            lat_op     <= ex_memop;
            lat_waddr  <= ex_waddr;
            lat_off    <= off_c;
        end else if ((state == WAIT) && dbus.ack) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            lat_op     <= OP_NONE;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written corner sequences,
// and random ops checked against an arithmetic model of the byte-lane rules.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata, ex_sdata;
    logic [3:0]  ex_memop;
    logic        stall_req, mem_reg, mem_excp;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_if #(.DW(32), .AW(32)) dbus ();

    mem_access #(.DW(32), .AW(32), .RAW(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_reg(ex_reg), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_memop(ex_memop), .ex_sdata(ex_sdata),
        .stall_req(stall_req), .dbus(dbus),
        .mem_reg(mem_reg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_excp(mem_excp)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        int          k;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] res;
        logic        excp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: lane rules expressed with plain arithmetic
    function automatic logic m_misaligned(input logic [3:0] op, input logic [31:0] addr);
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return (addr % 2) != 0;
        if (op == 4'd5 || op == 4'd8)               return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 4'(1 << off);
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] s);
        if (op == 4'd6) return (s & 32'hFF) * 32'h0101_0101;
        if (op == 4'd7) return (s & 32'hFFFF) * 32'h0001_0001;
        return s;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (op)
            4'd1:    return (b >= 128) ? b - 32'd256 : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            4'd4:    return h;
            default: return rd;
        endcase
    endfunction

    // Issue one memory op and answer with ack in the k-th cycle after issue
    task automatic apply(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] waddr, input int k, input logic [3:0] be,
                         input logic [31:0] bwd, input logic [31:0] res, input logic excp);
        logic st, ld;
        st = (op >= 4'd6) && (op <= 4'd8);
        ld = (op >= 4'd1) && (op <= 4'd5);
        ex_valid = 1'b1; ex_reg = ld; ex_waddr = waddr;
        ex_wdata = addr; ex_memop = op; ex_sdata = sdata;
        @(negedge clk);
        check({nm, " issue req"}, 32'(dbus.req), 32'd0);
        check({nm, " excp"}, 32'(mem_excp), 32'(excp));
        check({nm, " issue mem_reg"}, 32'(mem_reg), 32'd0);
        check({nm, " issue stall"}, 32'(stall_req), 32'(!excp));
        @(posedge clk); #1;
        if (excp) begin
            ex_valid = 1'b0;
            @(negedge clk);
            check({nm, " excp pulse"}, 32'(mem_excp), 32'd0);
            check({nm, " excp no req"}, 32'(dbus.req), 32'd0);
            @(posedge clk); #1;
            return;
        end
        // EX contents are frozen upstream; scrambling them must not matter here
        ex_valid = 1'($urandom); ex_reg = 1'($urandom); ex_waddr = 5'($urandom);
        ex_wdata = $urandom; ex_memop = 4'($urandom); ex_sdata = $urandom;
        for (int i = 1; i <= k; i++) begin
            dbus.ack   = (i == k);
            dbus.rdata = (i == k) ? rdata : $urandom;
            @(negedge clk);
            check({nm, " req"}, 32'(dbus.req), 32'd1);
            check({nm, " we"}, 32'(dbus.we), 32'(st));
            check({nm, " addr"}, dbus.addr, {addr[31:2], 2'b00});
            check({nm, " be"}, 32'(dbus.be), 32'(be));
            if (st) check({nm, " bus wdata"}, dbus.wdata, bwd);
            if (i < k) begin
                check({nm, " wait stall"}, 32'(stall_req), 32'd1);
                check({nm, " wait mem_reg"}, 32'(mem_reg), 32'd0);
            end else begin
                check({nm, " ack stall"}, 32'(stall_req), 32'd0);
                check({nm, " ack mem_reg"}, 32'(mem_reg), 32'(ld));
                if (ld) begin
                    check({nm, " ack waddr"}, 32'(mem_waddr), 32'(waddr));
                    check({nm, " ack result"}, mem_wdata, res);
                end
            end
            @(posedge clk); #1;
        end
        dbus.ack = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic pass_through(input logic v, input logic r, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [3:0] op);
        ex_valid = v; ex_reg = r; ex_waddr = wa; ex_wdata = wd; ex_memop = op;
        ex_sdata = $urandom;
        dbus.ack = 1'($urandom);
        @(negedge clk);
        check("pass mem_reg", 32'(mem_reg), 32'(v & r));
        check("pass waddr", 32'(mem_waddr), 32'(wa));
        check("pass wdata", mem_wdata, wd);
        check("pass stall", 32'(stall_req), 32'd0);
        check("pass excp", 32'(mem_excp), 32'd0);
        @(posedge clk); #1;
        dbus.ack = 1'b0;
        @(negedge clk);
        check("pass no req", 32'(dbus.req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{op:4'd1, addr:32'h103, sdata:0, rdata:32'h80AABBCC, waddr:5'd8,  k:4,
                     be:4'h8, bwd:0, res:32'hFFFFFF80, excp:1'b0};
        vecs[1]  = '{op:4'd4, addr:32'h202, sdata:0, rdata:32'h9ABC1234, waddr:5'd9,  k:1,
                     be:4'hC, bwd:0, res:32'h00009ABC, excp:1'b0};
        vecs[2]  = '{op:4'd5, addr:32'h200, sdata:0, rdata:32'h9ABC1234, waddr:5'd10, k:2,
                     be:4'hF, bwd:0, res:32'h9ABC1234, excp:1'b0};
        vecs[3]  = '{op:4'd7, addr:32'h302, sdata:32'hDEADBEEF, rdata:0, waddr:5'd0,  k:3,
                     be:4'hC, bwd:32'hBEEFBEEF, res:0, excp:1'b0};
        vecs[4]  = '{op:4'd5, addr:32'h401, sdata:0, rdata:0, waddr:5'd3, k:1,
                     be:4'h0, bwd:0, res:0, excp:1'b1};
        vecs[5]  = '{op:4'd2, addr:32'h101, sdata:0, rdata:32'h80AABBCC, waddr:5'd11, k:1,
                     be:4'h2, bwd:0, res:32'h000000BB, excp:1'b0};
        vecs[6]  = '{op:4'd3, addr:32'h102, sdata:0, rdata:32'h80AABBCC, waddr:5'd12, k:2,
                     be:4'hC, bwd:0, res:32'hFFFF80AA, excp:1'b0};
        vecs[7]  = '{op:4'd6, addr:32'h502, sdata:32'h12345678, rdata:0, waddr:5'd0, k:1,
                     be:4'h4, bwd:32'h78787878, res:0, excp:1'b0};
        vecs[8]  = '{op:4'd8, addr:32'h600, sdata:32'hCAFEF00D, rdata:0, waddr:5'd0, k:2,
                     be:4'hF, bwd:32'hCAFEF00D, res:0, excp:1'b0};
        vecs[9]  = '{op:4'd3, addr:32'h203, sdata:0, rdata:0, waddr:5'd4, k:1,
                     be:4'h0, bwd:0, res:0, excp:1'b1};
        vecs[10] = '{op:4'd7, addr:32'h301, sdata:32'h1, rdata:0, waddr:5'd0, k:1,
                     be:4'h0, bwd:0, res:0, excp:1'b1};
        vecs[11] = '{op:4'd1, addr:32'h100, sdata:0, rdata:32'h0000007F, waddr:5'd13, k:3,
                     be:4'h1, bwd:0, res:32'h0000007F, excp:1'b0};

        rst = 1'b1; ex_valid = 1'b0; ex_reg = 1'b0; ex_waddr = '0; ex_wdata = '0;
        ex_memop = '0; ex_sdata = '0; dbus.ack = 1'b0; dbus.rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset req", 32'(dbus.req), 32'd0);
        check("reset we", 32'(dbus.we), 32'd0);
        check("reset addr", dbus.addr, 32'd0);
        check("reset be", 32'(dbus.be), 32'd0);
        check("reset wdata", dbus.wdata, 32'd0);
        check("reset stall", 32'(stall_req), 32'd0);
        check("reset mem_reg", 32'(mem_reg), 32'd0);
        check("reset excp", 32'(mem_excp), 32'd0);
        @(posedge clk); #1;

        pass_through(1'b1, 1'b1, 5'd5, 32'h1234, 4'd0);

        foreach (vecs[i])
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].sdata,
                  vecs[i].rdata, vecs[i].waddr, vecs[i].k, vecs[i].be, vecs[i].bwd,
                  vecs[i].res, vecs[i].excp);

        // Abandon a transaction with reset after a long ack-less wait
        ex_valid = 1'b1; ex_reg = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h700;
        ex_memop = 4'd5; ex_sdata = '0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("rstwait req", 32'(dbus.req), 32'd1);
            check("rstwait stall", 32'(stall_req), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstwait req dropped", 32'(dbus.req), 32'd0);
        check("rstwait stall cleared", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        dbus.ack = 1'b1; dbus.rdata = 32'h55AA55AA;
        @(negedge clk);
        check("late ack mem_reg", 32'(mem_reg), 32'd0);
        check("late ack stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        dbus.ack = 1'b0;
        @(negedge clk);
        check("late ack no req", 32'(dbus.req), 32'd0);
        @(posedge clk); #1;
        apply("post-reset LW", 4'd5, 32'h800, 32'h0, 32'h01020304, 5'd6, 2, 4'hF,
              32'h0, 32'h01020304, 1'b0);

        // Random memory ops mixed with ALU pass-through cycles
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic v;
                logic [3:0] op;
                v  = 1'($urandom);
                op = v ? ($urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(9, 15)))
                       : 4'($urandom);
                pass_through(v, 1'($urandom), 5'($urandom), $urandom, op);
            end else begin
                logic [3:0]  op;
                logic [31:0] a, s, r;
                op = 4'($urandom_range(1, 8));
                a = $urandom; s = $urandom; r = $urandom;
                apply($sformatf("rand%0d op%0d", n, op), op, a, s, r, 5'($urandom),
                      $urandom_range(1, 4), m_be(op, a), m_wdata(op, s),
                      m_load(op, a, r), m_misaligned(op, a));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
